matrix_piedec: RTL and testbench
================================

Name: matrix_piedec

Overview:
PIE decoder, the receive-side counterpart of the PIE encoder. It recovers the reader-to-tag PIE waveform: delimiter, data-0, RTcal, an optional TRcal, then data symbols.
Used for TX loopback self-check and on-chip tag-side verification.
Measures pulse widths in Clk cycles, computes the 0/1 pivot from the calibration symbols, and emits a decoded bit stream with frame start/done and error strobes.

Parameters:
Tp, 1, simulation delay on register updates
CNT_W, 16, width of all length counters and length inputs/outputs

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
rx_PieIn  in  1  raw PIE line (asynchronous to Clk); idle level 0
r_DelimMin  in  CNT_W  minimum low run (cycles) qualifying as a delimiter
r_EofTimeout  in  CNT_W  low run ending a frame; requires r_PiePWLen < r_EofTimeout < r_DelimMin
r_MaxHigh  in  CNT_W  maximum legal high run
rx_FrameStart  out  1  one-cycle pulse: delimiter accepted, data-0 rising edge seen
rx_BitValid  out  1  one-cycle pulse: rx_Bit valid
rx_Bit  out  1  decoded data bit
rx_PreambleDet  out  1  level, set when TRcal was detected in the current frame
rx_RTCalHigh  out  CNT_W  measured RTcal high time
rx_TRCalHigh  out  CNT_W  measured TRcal high time; 0 if absent
rx_BitCount  out  CNT_W  bits decoded in the current frame
rx_FrameDone  out  1  one-cycle pulse: EOF timeout after at least one symbol
rx_Error  out  1  one-cycle pulse: protocol violation, decoder returns to IDLE

Behaviour:
- Input path: 2-flop synchronizer (s1, s2) plus history flop s3. Edge detected when s2 != s3. All timing is in the synchronized domain.
- Run counter RunCnt:
  - Loads 1 on an edge cycle; otherwise increments and saturates at all-ones.
  - At an edge, RunCnt holds the exact length N of the run just ended.
- Reset: all outputs 0, RunCnt 0, state IDLE, s1/s2/s3 0.
- States:
  - IDLE: on rise, if RunCnt >= r_DelimMin, pulse rx_FrameStart, clear rx_PreambleDet/rx_TRCalHigh/rx_BitCount, go D0_HI. Else stay in IDLE.
  - D0_HI: on fall, go D0_LO (data-0 high stored for debug only).
  - D0_LO: on rise, go RT_HI.
  - RT_HI: on fall, latch rx_RTCalHigh = N, go RT_LO.
  - RT_LO: on rise, latch PW = N, compute Pivot = (rx_RTCalHigh - PW) >> 1, go FIRST_HI. If rx_RTCalHigh <= PW, raise rx_Error and go IDLE.
  - FIRST_HI: on fall, if N > rx_RTCalHigh, treat the symbol as TRcal: set rx_PreambleDet, latch rx_TRCalHigh = N, no bit. Otherwise decode as a data bit. Either way go DATA_LO.
  - DATA_LO: on rise, go DATA_HI. If RunCnt > r_EofTimeout while low, pulse rx_FrameDone and go IDLE; RunCnt keeps counting so the next delimiter qualifies.
  - DATA_HI: on fall, decode the bit and go DATA_LO.
- Bit decode: rx_Bit = (N > Pivot). Pulse rx_BitValid, rx_BitCount += 1 (saturating).
- Errors (rx_Error pulse, go IDLE):
  - high run > r_MaxHigh in any *_HI state;
  - low run > r_EofTimeout in D0_LO or RT_LO.
  - In IDLE, a rise with RunCnt < r_DelimMin is ignored silently.
- Latency: pin change sampled at edge k; rx_BitValid/rx_FrameStart/rx_Error are visible after edge k+2 and last one cycle.
- An EOF in DATA_LO immediately after FIRST_HI detected TRcal (zero bits) still pulses rx_FrameDone.
- Reset mid-frame: immediate return to IDLE with outputs cleared; no FrameDone.
- rx_FrameDone, rx_Error and rx_FrameStart are mutually exclusive per cycle.
- Output hold: rx_RTCalHigh, rx_TRCalHigh and rx_BitCount are held until the next rx_FrameStart.
- Width rules: all arithmetic is unsigned CNT_W. The Pivot subtraction is guarded by the RT_LO check.

Decomposition:
- Add state encodings (IDLE..DATA_HI, 4-bit) and CNT_W to matrix_defines.v.
- One sub-module, matrix_pieDecPulseMeter: synchronizer, edge detect, RunCnt with saturation. Outputs: Rise, Fall, Level, RunCnt.
- FSM and decode logic stay in matrix_piedec.

Test Plan:
Common settings: r_DelimMin=40, r_EofTimeout=32, r_MaxHigh=200.
- Frame-sync: delimiter low 50, data-0 high 8/low 4, RTcal high 28/low 4, data 0,1,1,0 (highs 8,16,16,8, lows 4), then idle low -> rx_FrameStart once; rx_RTCalHigh=28, Pivot=12; bits 0,1,1,0; rx_BitCount=4; rx_PreambleDet=0; rx_FrameDone 32 cycles after last fall (+3 latency).
- Preamble: same frame with TRcal high 60/low 4 inserted after RTcal -> rx_PreambleDet=1, rx_TRCalHigh=60, same 4 bits, no bit emitted for TRcal.
- Loopback: drive rx_PieIn from the PIE encoder with Data0Len=8, Data1Len=16, PiePWLen=4, RTCalLen=28, Delimiter=50, sending 0xA5 -> decoded bits 1,0,1,0,0,1,0,1.
- Short delimiter: low 20 then a valid symbol train -> no rx_FrameStart, no bits, no rx_Error.
- Errors: high of 250 in DATA_HI -> rx_Error pulse, state IDLE. RTcal high 3 with PW 4 -> rx_Error at RT_LO rise.
- Reset asserted mid-frame after 2 bits -> all outputs 0 and no rx_FrameDone. The next valid frame decodes correctly with rx_BitCount restarting at 1.

Source files
------------

// File: rtl/matrix_piedec_pkg.sv
// matrix_piedec_pkg: shared types and defaults for the PIE receive decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_piedec_pkg;

    // Default width of every run-length counter and length port.
    localparam int PIE_CNT_W = 16;

    // Decoder states, in the order the PIE preamble is walked.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_D0_HI    = 4'd1,
        ST_D0_LO    = 4'd2,
        ST_RT_HI    = 4'd3,
        ST_RT_LO    = 4'd4,
        ST_FIRST_HI = 4'd5,
        ST_DATA_LO  = 4'd6,
        ST_DATA_HI  = 4'd7
    } pieState_t;

endpackage

// File: rtl/matrix_piedec_if.sv
// matrix_piedec_if: configuration lengths in, decoded stream and frame status out.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is a one-cycle pulse the consumer must take.
// Ports: r_DelimMin/r_EofTimeout/r_MaxHigh (config), rx_* (decoder results).
// master = decoder side, slave = consumer/configuration side.
interface matrix_piedec_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] r_DelimMin;
    logic [CNT_W-1:0] r_EofTimeout;
    logic [CNT_W-1:0] r_MaxHigh;

    logic             rx_FrameStart;
    logic             rx_BitValid;
    logic             rx_Bit;
    logic             rx_PreambleDet;
    logic [CNT_W-1:0] rx_RTCalHigh;
    logic [CNT_W-1:0] rx_TRCalHigh;
    logic [CNT_W-1:0] rx_BitCount;
    logic             rx_FrameDone;
    logic             rx_Error;

    modport master (
        input  r_DelimMin, r_EofTimeout, r_MaxHigh,
        output rx_FrameStart, rx_BitValid, rx_Bit, rx_PreambleDet,
               rx_RTCalHigh, rx_TRCalHigh, rx_BitCount, rx_FrameDone, rx_Error
    );

    modport slave (
        output r_DelimMin, r_EofTimeout, r_MaxHigh,
        input  rx_FrameStart, rx_BitValid, rx_Bit, rx_PreambleDet,
               rx_RTCalHigh, rx_TRCalHigh, rx_BitCount, rx_FrameDone, rx_Error
    );
endinterface

// File: rtl/matrix_piedec_pulsemeter.sv
// matrix_pieDecPulseMeter: synchronizes the PIE line and measures run lengths.
// Latency: pin sampled at edge k gives Rise/Fall combinationally during cycle after edge k+1.
// Backpressure: none.
// Ports: Clk, Reset (async, active high), PieIn (async line) ->
//        Rise/Fall (edge cycle strobes), Level (synchronized line), RunCnt (run length).
module matrix_pieDecPulseMeter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PieIn,
    output logic             Rise,
    output logic             Fall,
    output logic             Level,
    output logic [CNT_W-1:0] RunCnt
);
    logic s1, s2, s3;
    logic isEdge;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PieIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign isEdge = s2 ^ s3;
    assign Rise   = s2 & ~s3;
    assign Fall   = ~s2 & s3;
    assign Level  = s2;

    // On an edge cycle RunCnt still holds the length of the run that just
    // ended; loading 1 makes it count the new run from its first cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RunCnt <= '0;
        end else if (isEdge) begin
            RunCnt <= CNT_W'(1);
        end else if (RunCnt != '1) begin
            RunCnt <= RunCnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/matrix_piedec.sv
// matrix_piedec: PIE decoder - delimiter/data-0/RTcal/optional TRcal sync, then data bits.
// Latency: strobes are registered; visible after edge k+2 for a pin change sampled at edge k.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
// Ports: Clk, Reset (async, active high), rx_PieIn (raw line, idle 0),
//        pieIf (master): config lengths in, decoded bits / calibration / frame strobes out.
module matrix_piedec
    import matrix_piedec_pkg::*;
#(
    parameter int CNT_W = PIE_CNT_W
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            rx_PieIn,
    matrix_piedec_if.master pieIf
);
    logic             rise, fall, level;
    logic [CNT_W-1:0] runCnt;
    logic [CNT_W-1:0] pivot;
    pieState_t        state, nextState;

    // Decisions made this cycle, registered into the outputs.
    logic evStart, evBit, evTrcal, evDone, evErr, evRtLatch, evPivot;
    logic runHigh, highTooLong, lowTooLong;

    matrix_pieDecPulseMeter #(.CNT_W(CNT_W)) meter (
        .Clk    (Clk),
        .Reset  (Reset),
        .PieIn  (rx_PieIn),
        .Rise   (rise),
        .Fall   (fall),
        .Level  (level),
        .RunCnt (runCnt)
    );

    // Polarity of the run RunCnt describes: on an edge cycle it is the run
    // that just ended (opposite of the new level).
    assign runHigh     = level ^ (rise | fall);
    assign highTooLong = runHigh && (runCnt > pieIf.r_MaxHigh);
    assign lowTooLong  = !runHigh && (runCnt > pieIf.r_EofTimeout);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        evStart   = 1'b0;
        evBit     = 1'b0;
        evTrcal   = 1'b0;
        evDone    = 1'b0;
        evErr     = 1'b0;
        evRtLatch = 1'b0;
        evPivot   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise && runCnt >= pieIf.r_DelimMin) begin
                    evStart   = 1'b1;
                    nextState = ST_D0_HI;
                end
            end
            ST_D0_HI: begin
                if (highTooLong)  evErr = 1'b1;
                else if (fall)    nextState = ST_D0_LO;
            end
            ST_D0_LO: begin
                if (lowTooLong)   evErr = 1'b1;
                else if (rise)    nextState = ST_RT_HI;
            end
            ST_RT_HI: begin
                if (highTooLong) begin
                    evErr = 1'b1;
                end else if (fall) begin
                    evRtLatch = 1'b1;
                    nextState = ST_RT_LO;
                end
            end
            ST_RT_LO: begin
                if (lowTooLong) begin
                    evErr = 1'b1;
                end else if (rise) begin
                    // RTcal must exceed PW or the pivot subtraction underflows.
                    if (pieIf.rx_RTCalHigh <= runCnt) begin
                        evErr = 1'b1;
                    end else begin
                        evPivot   = 1'b1;
                        nextState = ST_FIRST_HI;
                    end
                end
            end
            ST_FIRST_HI: begin
                if (highTooLong) begin
                    evErr = 1'b1;
                end else if (fall) begin
                    // A symbol longer than RTcal can only be TRcal.
                    if (runCnt > pieIf.rx_RTCalHigh) evTrcal = 1'b1;
                    else                             evBit   = 1'b1;
                    nextState = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (lowTooLong) begin
                    evDone    = 1'b1;
                    nextState = ST_IDLE;
                end else if (rise) begin
                    nextState = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (highTooLong) begin
                    evErr = 1'b1;
                end else if (fall) begin
                    evBit     = 1'b1;
                    nextState = ST_DATA_LO;
                end
            end
            default: nextState = ST_IDLE;
        endcase
        if (evErr) nextState = ST_IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pieIf.rx_FrameStart  <= 1'b0;
            pieIf.rx_BitValid    <= 1'b0;
            pieIf.rx_Bit         <= 1'b0;
            pieIf.rx_PreambleDet <= 1'b0;
            pieIf.rx_RTCalHigh   <= '0;
            pieIf.rx_TRCalHigh   <= '0;
            pieIf.rx_BitCount    <= '0;
            pieIf.rx_FrameDone   <= 1'b0;
            pieIf.rx_Error       <= 1'b0;
            pivot                <= '0;
        end else begin
            pieIf.rx_FrameStart <= evStart;
            pieIf.rx_FrameDone  <= evDone;
            pieIf.rx_Error      <= evErr;
            pieIf.rx_BitValid   <= evBit;
            if (evStart) begin
                pieIf.rx_PreambleDet <= 1'b0;
                pieIf.rx_TRCalHigh   <= '0;
                pieIf.rx_BitCount    <= '0;
            end
            if (evRtLatch) pieIf.rx_RTCalHigh <= runCnt;
            if (evPivot)   pivot <= (pieIf.rx_RTCalHigh - runCnt) >> 1;
            if (evTrcal) begin
                pieIf.rx_PreambleDet <= 1'b1;
                pieIf.rx_TRCalHigh   <= runCnt;
            end
            if (evBit) begin
                pieIf.rx_Bit <= (runCnt > pivot);
                if (pieIf.rx_BitCount != '1)
                    pieIf.rx_BitCount <= pieIf.rx_BitCount + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_matrix_piedec.sv
// tb_matrix_piedec: directed-vector bench for the PIE decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_piedec;
    import matrix_piedec_pkg::*;

    localparam int CNT_W = 16;

    logic Clk;
    logic Reset;
    logic rx_PieIn;

    matrix_piedec_if #(.CNT_W(CNT_W)) pieIf ();

    matrix_piedec #(.CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .rx_PieIn (rx_PieIn),
        .pieIf    (pieIf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastFallCyc = 0;
    int riseCyc = 0;

    // Monitor: record strobes on the falling edge, away from the active edge.
    int startCnt = 0, doneCnt = 0, errCnt = 0, exclViol = 0;
    int startCyc = 0, doneCyc = 0, errCyc = 0;
    logic             bitQ[$];
    logic [CNT_W-1:0] cntQ[$];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (pieIf.rx_FrameStart) begin startCnt <= startCnt + 1; startCyc <= cyc; end
        if (pieIf.rx_FrameDone)  begin doneCnt  <= doneCnt + 1;  doneCyc  <= cyc; end
        if (pieIf.rx_Error)      begin errCnt   <= errCnt + 1;   errCyc   <= cyc; end
        if (pieIf.rx_BitValid) begin
            bitQ.push_back(pieIf.rx_Bit);
            cntQ.push_back(pieIf.rx_BitCount);
        end
        if (int'(pieIf.rx_FrameStart) + int'(pieIf.rx_FrameDone) + int'(pieIf.rx_Error) > 1)
            exclViol <= exclViol + 1;
    end

    function automatic int packBits(input int base);
        int v = 0;
        for (int i = base; i < bitQ.size(); i++) v = (v << 1) | int'(bitQ[i]);
        return v;
    endfunction

    // Hold the line at lvl for n sampling edges; returns 1 time unit after the last.
    task automatic drive(input logic lvl, input int n);
        rx_PieIn = lvl;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic symbol(input int hi, input int lo);
        drive(1'b1, hi);
        lastFallCyc = cyc;
        drive(1'b0, lo);
    endtask

    task automatic preamble(input int rt, input int tr);
        drive(1'b0, 50);
        riseCyc = cyc;
        symbol(8, 4);
        symbol(rt, 4);
        if (tr > 0) symbol(tr, 4);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) symbol(bits[i] ? 16 : 8, 4);
    endtask

    // Reference PIE encoder: Data0=8, Data1=16, PW=4, RTcal=28, delimiter=50, MSB first.
    task automatic pie_encode(input logic [7:0] data);
        drive(1'b0, 50);
        symbol(8, 4);
        symbol(28, 4);
        for (int i = 7; i >= 0; i--) symbol(data[i] ? 16 : 8, 4);
        drive(1'b0, 41);
    endtask

    task automatic test_reset;
        logic [6*1+3*CNT_W-1:0] outs;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        outs = {pieIf.rx_FrameStart, pieIf.rx_BitValid, pieIf.rx_Bit, pieIf.rx_PreambleDet,
                pieIf.rx_FrameDone, pieIf.rx_Error, pieIf.rx_RTCalHigh, pieIf.rx_TRCalHigh,
                pieIf.rx_BitCount};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
        checks++;
        if (dut.runCnt !== '0) begin errors++; $display("FAIL reset_runcnt: got %0d expected 0", dut.runCnt); end
        Reset = 1'b0;
    endtask

    task automatic test_short_delim;
        int s0 = startCnt, e0 = errCnt, b0 = bitQ.size();
        drive(1'b1, 8);
        drive(1'b0, 20);
        symbol(8, 4);
        symbol(28, 4);
        symbol(8, 4);
        symbol(16, 4);
        drive(1'b0, 10);
        checks++;
        if (startCnt - s0 !== 0) begin errors++; $display("FAIL short_delim_start: got %0d expected 0", startCnt - s0); end
        checks++;
        if (bitQ.size() - b0 !== 0) begin errors++; $display("FAIL short_delim_bits: got %0d expected 0", bitQ.size() - b0); end
        checks++;
        if (errCnt - e0 !== 0) begin errors++; $display("FAIL short_delim_error: got %0d expected 0", errCnt - e0); end
    endtask

    task automatic test_frame_sync;
        int s0 = startCnt, d0 = doneCnt, e0 = errCnt, b0 = bitQ.size();
        preamble(28, 0);
        send_bits(16'b0110, 4);
        drive(1'b0, 41);
        checks++;
        if (startCnt - s0 !== 1) begin errors++; $display("FAIL fs_start_count: got %0d expected 1", startCnt - s0); end
        checks++;
        if (startCyc - riseCyc !== 3) begin errors++; $display("FAIL fs_start_latency: got %0d expected 3", startCyc - riseCyc); end
        checks++;
        if (bitQ.size() - b0 !== 4) begin errors++; $display("FAIL fs_bit_count: got %0d expected 4", bitQ.size() - b0); end
        checks++;
        if (packBits(b0) !== 6) begin errors++; $display("FAIL fs_bits: got %b expected 0110", packBits(b0)); end
        checks++;
        if (pieIf.rx_BitCount !== 4) begin errors++; $display("FAIL fs_rx_bitcount: got %0d expected 4", pieIf.rx_BitCount); end
        checks++;
        if (pieIf.rx_RTCalHigh !== 28) begin errors++; $display("FAIL fs_rtcal: got %0d expected 28", pieIf.rx_RTCalHigh); end
        checks++;
        if (dut.pivot !== 12) begin errors++; $display("FAIL fs_pivot: got %0d expected 12", dut.pivot); end
        checks++;
        if (pieIf.rx_PreambleDet !== 1'b0) begin errors++; $display("FAIL fs_preamble: got %b expected 0", pieIf.rx_PreambleDet); end
        checks++;
        if (pieIf.rx_TRCalHigh !== 0) begin errors++; $display("FAIL fs_trcal: got %0d expected 0", pieIf.rx_TRCalHigh); end
        checks++;
        if (doneCnt - d0 !== 1) begin errors++; $display("FAIL fs_done_count: got %0d expected 1", doneCnt - d0); end
        checks++;
        if (doneCyc - lastFallCyc !== 36) begin errors++; $display("FAIL fs_done_latency: got %0d expected 36", doneCyc - lastFallCyc); end
        checks++;
        if (errCnt - e0 !== 0) begin errors++; $display("FAIL fs_error: got %0d expected 0", errCnt - e0); end
    endtask

    task automatic test_preamble;
        int s0 = startCnt, d0 = doneCnt, b0 = bitQ.size();
        preamble(28, 60);
        send_bits(16'b0110, 4);
        drive(1'b0, 41);
        checks++;
        if (startCnt - s0 !== 1) begin errors++; $display("FAIL pre_start_count: got %0d expected 1", startCnt - s0); end
        checks++;
        if (pieIf.rx_PreambleDet !== 1'b1) begin errors++; $display("FAIL pre_detect: got %b expected 1", pieIf.rx_PreambleDet); end
        checks++;
        if (pieIf.rx_TRCalHigh !== 60) begin errors++; $display("FAIL pre_trcal: got %0d expected 60", pieIf.rx_TRCalHigh); end
        checks++;
        if (bitQ.size() - b0 !== 4) begin errors++; $display("FAIL pre_bit_count: got %0d expected 4", bitQ.size() - b0); end
        checks++;
        if (packBits(b0) !== 6) begin errors++; $display("FAIL pre_bits: got %b expected 0110", packBits(b0)); end
        checks++;
        if (pieIf.rx_BitCount !== 4) begin errors++; $display("FAIL pre_rx_bitcount: got %0d expected 4", pieIf.rx_BitCount); end
        checks++;
        if (doneCnt - d0 !== 1) begin errors++; $display("FAIL pre_done_count: got %0d expected 1", doneCnt - d0); end
    endtask

    task automatic test_loopback;
        int d0 = doneCnt, b0 = bitQ.size();
        pie_encode(8'hA5);
        checks++;
        if (bitQ.size() - b0 !== 8) begin errors++; $display("FAIL lb_bit_count: got %0d expected 8", bitQ.size() - b0); end
        checks++;
        if (packBits(b0) !== 32'hA5) begin errors++; $display("FAIL lb_bits: got %h expected a5", packBits(b0)); end
        checks++;
        if (pieIf.rx_BitCount !== 8) begin errors++; $display("FAIL lb_rx_bitcount: got %0d expected 8", pieIf.rx_BitCount); end
        checks++;
        if (pieIf.rx_PreambleDet !== 1'b0) begin errors++; $display("FAIL lb_preamble: got %b expected 0", pieIf.rx_PreambleDet); end
        checks++;
        if (doneCnt - d0 !== 1) begin errors++; $display("FAIL lb_done_count: got %0d expected 1", doneCnt - d0); end
    endtask

    task automatic test_error_maxhigh;
        int d0 = doneCnt, e0 = errCnt, b0 = bitQ.size();
        int hiCyc;
        preamble(28, 0);
        symbol(8, 4);
        hiCyc = cyc;
        drive(1'b1, 250);
        checks++;
        if (errCnt - e0 !== 1) begin errors++; $display("FAIL maxhigh_error_count: got %0d expected 1", errCnt - e0); end
        checks++;
        if (errCyc - hiCyc !== 204) begin errors++; $display("FAIL maxhigh_error_latency: got %0d expected 204", errCyc - hiCyc); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL maxhigh_state: got %0d expected 0", dut.state); end
        checks++;
        if (bitQ.size() - b0 !== 1) begin errors++; $display("FAIL maxhigh_bits: got %0d expected 1", bitQ.size() - b0); end
        drive(1'b0, 60);
        checks++;
        if (doneCnt - d0 !== 0) begin errors++; $display("FAIL maxhigh_done: got %0d expected 0", doneCnt - d0); end
    endtask

    task automatic test_error_rtcal;
        int s0 = startCnt, d0 = doneCnt, e0 = errCnt, b0 = bitQ.size();
        int pwRiseCyc;
        drive(1'b0, 50);
        symbol(8, 4);
        symbol(3, 4);
        pwRiseCyc = cyc;
        drive(1'b1, 8);
        drive(1'b0, 60);
        checks++;
        if (startCnt - s0 !== 1) begin errors++; $display("FAIL rtcal_start: got %0d expected 1", startCnt - s0); end
        checks++;
        if (errCnt - e0 !== 1) begin errors++; $display("FAIL rtcal_error_count: got %0d expected 1", errCnt - e0); end
        checks++;
        if (errCyc - pwRiseCyc !== 3) begin errors++; $display("FAIL rtcal_error_latency: got %0d expected 3", errCyc - pwRiseCyc); end
        checks++;
        if (bitQ.size() - b0 !== 0) begin errors++; $display("FAIL rtcal_bits: got %0d expected 0", bitQ.size() - b0); end
        checks++;
        if (doneCnt - d0 !== 0) begin errors++; $display("FAIL rtcal_done: got %0d expected 0", doneCnt - d0); end
    endtask

    task automatic test_reset_midframe;
        int d0 = doneCnt, b0 = bitQ.size();
        int b1;
        logic [6*1+3*CNT_W-1:0] outs;
        preamble(28, 0);
        send_bits(16'b10, 2);
        drive(1'b1, 5);
        checks++;
        if (bitQ.size() - b0 !== 2) begin errors++; $display("FAIL mid_bits_before: got %0d expected 2", bitQ.size() - b0); end
        Reset = 1'b1;
        rx_PieIn = 1'b0;
        #1;
        outs = {pieIf.rx_FrameStart, pieIf.rx_BitValid, pieIf.rx_Bit, pieIf.rx_PreambleDet,
                pieIf.rx_FrameDone, pieIf.rx_Error, pieIf.rx_RTCalHigh, pieIf.rx_TRCalHigh,
                pieIf.rx_BitCount};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        drive(1'b0, 60);
        checks++;
        if (doneCnt - d0 !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", doneCnt - d0); end
        b1 = bitQ.size();
        preamble(28, 0);
        send_bits(16'b101, 3);
        drive(1'b0, 41);
        checks++;
        if (bitQ.size() - b1 !== 3) begin errors++; $display("FAIL mid_next_bit_count: got %0d expected 3", bitQ.size() - b1); end
        else begin
            checks++;
            if (cntQ[b1] !== 1) begin errors++; $display("FAIL mid_first_bitcount: got %0d expected 1", cntQ[b1]); end
        end
        checks++;
        if (packBits(b1) !== 5) begin errors++; $display("FAIL mid_next_bits: got %b expected 101", packBits(b1)); end
        checks++;
        if (doneCnt - d0 !== 1) begin errors++; $display("FAIL mid_next_done: got %0d expected 1", doneCnt - d0); end
    endtask

    task automatic test_exclusive;
        checks++;
        if (exclViol !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", exclViol); end
    endtask

    initial begin
        Reset    = 1'b0;
        rx_PieIn = 1'b0;
        pieIf.r_DelimMin   = 16'd40;
        pieIf.r_EofTimeout = 16'd32;
        pieIf.r_MaxHigh    = 16'd200;
        #2;
        test_reset();
        test_short_delim();
        test_frame_sync();
        test_preamble();
        test_loopback();
        test_error_maxhigh();
        test_error_rtcal();
        test_reset_midframe();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
